// File: rtl/iterative_shift_right_if.sv
// Handshake and data bundle for the iterative right shifter.
// The master issues start/operands; the slave returns busy/done/result.
interface iterative_shift_right_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output start, in_data, shamt, arith,
    input  busy, done, out_data
  );

  modport slave (
    input  start, in_data, shamt, arith,
    output busy, done, out_data
  );
endinterface

// File: rtl/iterative_shift_right.sv
// Multi-cycle right shifter (logical/arithmetic), one bit position per clock.
// The result register holds its value from the done cycle until the next completion.
module iterative_shift_right #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  iterative_shift_right_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   work;
  logic               fill;
  logic [WIDTH-1:0]   result;

  // The fill bit is latched at capture, so every step shifts in the same value.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w,
                                                  input logic             f);
    return {f, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      fill   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state <= SHIFT;
            work  <= bus.in_data;
            cnt   <= bus.shamt;
            fill  <= bus.arith & bus.in_data[WIDTH-1];
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // One extra SHIFT cycle at cnt==0 moves the finished word into result.
          if (cnt != '0) begin
            work <= shift_step(work, fill);
            cnt  <= cnt - SHAMT_W'(1);
          end else begin
            result <= work;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.out_data = result;

endmodule

// File: tb/tb_iterative_shift_right.sv
// Self-checking bench for iterative_shift_right: a cycle-level reference model
// built on the >> / >>> operators, directed literal cases and a random phase.
module tb_iterative_shift_right;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iterative_shift_right_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus();

  iterative_shift_right #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors     = 0;
  int checks     = 0;
  int done_count = 0;

  bit          m_on   = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_out  = '0;
  logic [31:0] m_pend = '0;
  int          m_left = 0;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int sh, input bit ar);
    if (ar) return $unsigned($signed(x) >>> sh);
    return x >> sh;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Reference: an accepted start keeps the unit busy for shamt+1 cycles, then one done cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_on   = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_out  = '0;
      m_left = 0;
    end else if (m_on) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_out  = m_pend;
        end
      end else if (bus.start) begin
        m_busy = 1'b1;
        m_left = int'(bus.shamt) + 1;
        m_pend = ref_shift(bus.in_data, int'(bus.shamt), bus.arith);
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("out_data", bus.out_data, m_out);
      if (bus.done === 1'b1) done_count++;
    end
  end

  task automatic run_op(input logic [31:0] d, input int sh, input bit ar,
                        input logic [31:0] exp_out, input int exp_lat, input string name);
    int n;
    bus.start   = 1'b1;
    bus.in_data = d;
    bus.shamt   = SHAMT_W'(sh);
    bus.arith   = ar;
    tick;
    bus.start   = 1'b0;
    bus.in_data = $urandom;
    bus.shamt   = SHAMT_W'($urandom);
    bus.arith   = 1'($urandom);
    n = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    check({name, " latency"}, 32'(n - 1), 32'(exp_lat));
    check({name, " result"}, bus.out_data, exp_out);
    tick;
  endtask

  initial begin
    int n;
    int c0;
    bus.start   = 1'b0;
    bus.in_data = '0;
    bus.shamt   = '0;
    bus.arith   = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset out", bus.out_data, 32'h0000_0000);
    rst = 1'b0;
    tick;

    run_op(32'h8000_0010, 4,  1'b0, 32'h0800_0001, 5,  "srl4");
    run_op(32'h8000_0010, 4,  1'b1, 32'hF800_0001, 5,  "sra4 neg");
    run_op(32'h7FFF_FFF0, 4,  1'b1, 32'h07FF_FFFF, 5,  "sra4 pos");
    run_op(32'h1234_5678, 0,  1'b0, 32'h1234_5678, 1,  "shamt0");
    run_op(32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, 32, "sra31");
    run_op(32'h8000_0000, 31, 1'b0, 32'h0000_0001, 32, "srl31");

    // A second start while busy must be dropped entirely.
    c0 = done_count;
    bus.start = 1'b1; bus.in_data = 32'hAABB_CCDD; bus.shamt = 5'd8; bus.arith = 1'b0;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    bus.start = 1'b1; bus.in_data = 32'hFFFF_FFFF; bus.shamt = 5'd1; bus.arith = 1'b1;
    tick;
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    check("ignored start result", bus.out_data, 32'h00AA_BBCC);
    repeat (6) tick;
    check("ignored start done pulses", 32'(done_count - c0), 32'd1);
    check("ignored start idle", 32'(bus.busy), 32'd0);

    // Start held high: one completion every shamt+2 cycles.
    bus.start = 1'b1; bus.in_data = 32'h0000_0010; bus.shamt = 5'd2; bus.arith = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("b2b first result", bus.out_data, 32'h0000_0004);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick;
        n++;
      end while (bus.done !== 1'b1 && n < 20);
      check("b2b period", 32'(n), 32'd4);
      check("b2b result", bus.out_data, 32'h0000_0004);
    end
    bus.start = 1'b0;
    repeat (6) tick;

    // Reset in the middle of a long shift.
    bus.start = 1'b1; bus.in_data = 32'h89AB_CDEF; bus.shamt = 5'd20; bus.arith = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (6) tick;
    rst = 1'b1;
    tick;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset out", bus.out_data, 32'h0000_0000);
    rst = 1'b0;
    c0 = done_count;
    repeat (25) tick;
    check("midreset no done", 32'(done_count - c0), 32'd0);
    run_op(32'hF000_0000, 4, 1'b1, 32'hFF00_0000, 5, "after reset");

    // Random traffic, including starts while busy and rare resets.
    for (int i = 0; i < 800; i++) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.in_data = $urandom;
      bus.shamt   = ($urandom_range(0, 1) == 0) ? SHAMT_W'($urandom_range(0, 3)) : SHAMT_W'($urandom);
      bus.arith   = 1'($urandom);
      rst         = ($urandom_range(0, 199) == 0);
      tick;
    end
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (40) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
